// File: rtl/job_arb_pkg.sv
// ============================================================================
// job_arb_pkg : shared constants, state encoding and helpers for job_rr_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package job_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/job_prio_enc8.sv
// ============================================================================
// job_prio_enc8 : 8-bit lowest-set-bit priority encoder (index 0 when empty)
// Revision 1.0
// ============================================================================
`default_nettype none

module job_prio_enc8
  import job_arb_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign valid = |vec;

endmodule

`default_nettype wire

// File: rtl/job_rr_arbiter.sv
// ============================================================================
// job_rr_arbiter : 8-way round-robin arbiter with grant hold and hold timeout
// Revision 1.0
// ============================================================================
`default_nettype none

module job_rr_arbiter
  import job_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             forced
);

  localparam logic [HOLD_W-1:0] C_HOLD_LAST =
      (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
  localparam bit C_HOLD_EN = (MAX_HOLD != 0);

  arb_state_t        state;
  logic [IDX_W-1:0]  ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic [IDX_W-1:0]  sel_ptr;
  logic [N_REQ-1:0]  sel_req;
  logic [N_REQ-1:0]  rot_req;
  logic [IDX_W-1:0]  enc_idx;
  logic              win_valid;
  logic [IDX_W-1:0]  win_idx;
  logic              owner_req;
  logic              hold_last;

  // While a grant is held, the next candidate is always searched from just
  // past the owner with the owner masked out; this serves both the normal
  // release (owner bit already low) and the timeout hand-off.
  always_comb begin
    sel_ptr = ptr;
    sel_req = req;
    if (state == OWN) begin
      sel_ptr = gnt_idx + 3'd1;
      sel_req = req & ~idx_to_onehot(gnt_idx);
    end
  end

  assign rot_req   = (sel_req >> sel_ptr) | (sel_req << (4'd8 - {1'b0, sel_ptr}));
  assign win_idx   = enc_idx + sel_ptr;
  assign owner_req = req[gnt_idx];
  assign hold_last = C_HOLD_EN && (hold_cnt == C_HOLD_LAST);

  job_prio_enc8 u_enc (
    .vec   (rot_req),
    .idx   (enc_idx),
    .valid (win_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      forced    <= 1'b0;
    end else begin
      forced <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            state     <= OWN;
            gnt       <= idx_to_onehot(win_idx);
            gnt_idx   <= win_idx;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
          end
        end
        OWN: begin
          if (!owner_req) begin
            ptr      <= gnt_idx + 3'd1;
            hold_cnt <= '0;
            if (win_valid) begin
              gnt     <= idx_to_onehot(win_idx);
              gnt_idx <= win_idx;
            end else begin
              state     <= IDLE;
              gnt       <= '0;
              gnt_idx   <= '0;
              gnt_valid <= 1'b0;
            end
          end else if (hold_last && win_valid) begin
            ptr      <= gnt_idx + 3'd1;
            hold_cnt <= '0;
            gnt      <= idx_to_onehot(win_idx);
            gnt_idx  <= win_idx;
            forced   <= 1'b1;
          end else if (C_HOLD_EN && !hold_last) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_job_rr_arbiter.sv
// ============================================================================
// tb_job_rr_arbiter : directed stimulus with a queue-based scoreboard
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_job_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       forced;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       forced;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  job_rr_arbiter #(.MAX_HOLD(16), .HOLD_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .forced    (forced)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue what the outputs must be after the
  // next rising edge.
  task automatic step(input logic r, input logic [7:0] rq,
                      input logic v, input logic [2:0] ix, input logic f);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    e.gnt    = v ? (8'h01 << ix) : 8'h00;
    e.idx    = ix;
    e.valid  = v;
    e.forced = f;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are registered, so every edge presents a new result.
  always @(posedge clk) begin
    #1;
    if (!done && exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a = '{gnt: gnt, idx: gnt_idx, valid: gnt_valid, forced: forced};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL outputs #%0d: got gnt=%h idx=%0d valid=%b forced=%b, want gnt=%h idx=%0d valid=%b forced=%b",
                 n_cmp, a.gnt, a.idx, a.valid, a.forced, e.gnt, e.idx, e.valid, e.forced);
      end
      if (gnt_valid !== (|gnt)) begin
        n_bad++;
        $display("FAIL valid_inv: got gnt_valid=%b, want %b", gnt_valid, |gnt);
      end
    end
  end

  initial begin
    // reset and idle
    step(1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
    repeat (5) step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0);

    // first grant, release with no bubble, release to idle (ptr -> 6)
    step(1'b0, 8'h24, 1'b1, 3'd2, 1'b0);
    step(1'b0, 8'h20, 1'b1, 3'd5, 1'b0);
    step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0);

    // wrap from ptr 6 to idx 0, hold 16 cycles, forced hand-off to idx 1
    step(1'b0, 8'h03, 1'b1, 3'd0, 1'b0);
    repeat (15) step(1'b0, 8'h03, 1'b1, 3'd0, 1'b0);
    step(1'b0, 8'h03, 1'b1, 3'd1, 1'b1);
    step(1'b0, 8'h03, 1'b1, 3'd1, 1'b0);

    // sole requester keeps the grant past the hold limit, never forced
    step(1'b0, 8'h08, 1'b1, 3'd3, 1'b0);
    repeat (40) step(1'b0, 8'h08, 1'b1, 3'd3, 1'b0);
    step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0);

    // fairness: all request, each releases after one grant cycle
    step(1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
    step(1'b0, 8'hFF, 1'b1, 3'd0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] drop;
      drop = ~(8'h01 << k);
      step(1'b0, drop, 1'b1, 3'(k + 1), 1'b0);
    end

    // reset while gnt=8'h10, then first grant is idx 0
    step(1'b0, 8'h10, 1'b1, 3'd4, 1'b0);
    step(1'b1, 8'h10, 1'b0, 3'd0, 1'b0);
    step(1'b0, 8'hFF, 1'b1, 3'd0, 1'b0);
    step(1'b0, 8'hFF, 1'b1, 3'd0, 1'b0);

    // owner release and a new request in the same cycle
    step(1'b0, 8'h02, 1'b1, 3'd1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0);

    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
